// File: rtl/morph_filter.sv
// morph_filter: 3x3 binary erosion/dilation over a video stream, two-line buffered, 2 clk latency.
module morph_filter #(
  parameter int MAX_WIDTH = 1024,
  parameter int MODE      = 0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic in_vsync,
  input  logic in_hsync,
  input  logic in_de,
  input  logic monoc,
  output logic post_vsync,
  output logic post_hsync,
  output logic post_de,
  output logic monoc_out
);
  localparam int   AW = (MAX_WIDTH > 1) ? $clog2(MAX_WIDTH) : 1;
  localparam int   CW = AW + 1;
  localparam logic N  = (MODE == 0);
  logic [CW-1:0] col_q, col_d;
  logic [1:0]    row_q, row_d;
  logic          vs_q, vs_d;
  logic [1:0]    s0_q, s0_d, s1_q, s1_d, s2_q, s2_d;
  logic [2:0]    d1_q, d1_d, d2_q, d2_d;
  logic          px1_q, px1_d, px2_q, px2_d;
  logic          lb0 [MAX_WIDTH];
  logic          lb1 [MAX_WIDTH];
  logic          vs_rise, in_rng, t1, t2, res;
  logic [1:0]    row_cur;
  logic [AW-1:0] addr;
  logic [8:0]    win;
  always_comb begin
    vs_rise = in_vsync & ~vs_q;
    row_cur = vs_rise ? 2'd0 : row_q;
    in_rng  = col_q < CW'(MAX_WIDTH);
    addr    = col_q[AW-1:0];
    // rows above the current one are masked by row, so stale buffer contents never matter
    t1      = (row_cur != 2'd0 && in_rng) ? lb0[addr] : N;
    t2      = (row_cur == 2'd2 && in_rng) ? lb1[addr] : N;
    win     = {monoc, t1, t2, s0_q, s1_q, s2_q};
    res     = (MODE == 0) ? &win : |win;
    col_d   = in_de ? col_q + CW'(~&col_q) : '0;
    row_d   = vs_rise ? 2'd0 : (d1_q[0] & ~in_de) ? row_q + 2'(row_q != 2'd2) : row_q;
    vs_d    = in_vsync;
    s0_d    = in_de ? {s0_q[0], monoc} : {N, N};
    s1_d    = in_de ? {s1_q[0], t1} : {N, N};
    s2_d    = in_de ? {s2_q[0], t2} : {N, N};
    d1_d    = {in_vsync, in_hsync, in_de};
    d2_d    = d1_q;
    px1_d   = in_de & res;
    px2_d   = px1_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q <= '0;
      row_q <= '0;
      vs_q  <= 1'b0;
      s0_q  <= {N, N};
      s1_q  <= {N, N};
      s2_q  <= {N, N};
      d1_q  <= '0;
      d2_q  <= '0;
      px1_q <= 1'b0;
      px2_q <= 1'b0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
      vs_q  <= vs_d;
      s0_q  <= s0_d;
      s1_q  <= s1_d;
      s2_q  <= s2_d;
      d1_q  <= d1_d;
      d2_q  <= d2_d;
      px1_q <= px1_d;
      px2_q <= px2_d;
    end
  end
  always_ff @(posedge clk) begin
    if (in_de && in_rng) begin
      lb0[addr] <= monoc;
      lb1[addr] <= lb0[addr];
    end
  end
  assign post_vsync = d2_q[2];
  assign post_hsync = d2_q[1];
  assign post_de    = d2_q[0];
  assign monoc_out  = px2_q;
endmodule

// File: tb/tb_morph_filter.sv
// tb_morph_filter: directed frames against erosion and dilation instances with hand-computed outputs.
module tb_morph_filter;
  logic clk = 0, rst_n = 0, in_vsync = 0, in_hsync = 0, in_de = 0, monoc = 0;
  logic pv0, ph0, pd0, mo0, pv1, ph1, pd1, mo1;
  int n_run = 0, n_fail = 0;
  logic sel = 0;
  logic [3:0] p1 = 0, p2 = 0;
  logic [15:0] img [6];
  logic [15:0] expv [6];
  always #5 clk = ~clk;
  morph_filter #(.MAX_WIDTH(8), .MODE(0)) u0 (
    .clk(clk), .rst_n(rst_n), .in_vsync(in_vsync), .in_hsync(in_hsync), .in_de(in_de), .monoc(monoc),
    .post_vsync(pv0), .post_hsync(ph0), .post_de(pd0), .monoc_out(mo0)
  );
  morph_filter #(.MAX_WIDTH(8), .MODE(1)) u1 (
    .clk(clk), .rst_n(rst_n), .in_vsync(in_vsync), .in_hsync(in_hsync), .in_de(in_de), .monoc(monoc),
    .post_vsync(pv1), .post_hsync(ph1), .post_de(pd1), .monoc_out(mo1)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask
  task automatic drive(input logic rn, input logic vs, input logic hs, input logic de, input logic px, input logic e);
    @(negedge clk);
    check("post_vsync", pv0, p2[3]);
    check("post_hsync", ph0, p2[2]);
    check("post_de", pd0, p2[1]);
    check("post_de_dil", pd1, p2[1]);
    check("post_vsync_dil", pv1, p2[3]);
    check("monoc_out", sel ? mo1 : mo0, p2[0]);
    rst_n = rn; in_vsync = vs; in_hsync = hs; in_de = de; monoc = px;
    p2 = p1;
    p1 = {vs, hs, de, de & e};
    if (!rn) begin
      p1 = 0;
      p2 = 0;
    end
  endtask
  task automatic idle(input int n);
    repeat (n) drive(1, 0, 0, 0, 0, 0);
  endtask
  task automatic line(input int w, input logic [15:0] pix, input logic [15:0] ex);
    for (int c = 0; c < w; c++) drive(1, 0, 0, 1, pix[c], ex[c]);
    drive(1, 0, 1, 0, 0, 0);
    idle(2);
  endtask
  task automatic vpulse();
    repeat (2) drive(1, 1, 0, 0, 0, 0);
    idle(2);
  endtask
  task automatic frame(input int rows, input int w);
    vpulse();
    for (int r = 0; r < rows; r++) line(w, img[r], expv[r]);
    idle(3);
  endtask
  initial begin
    repeat (3) drive(0, 0, 0, 0, 0, 0);
    idle(2);
    sel = 0;
    for (int r = 0; r < 6; r++) begin img[r] = 16'h3F; expv[r] = 16'h3F; end
    frame(4, 6);
    img[1] = 16'h3B;
    for (int r = 1; r < 4; r++) expv[r] = 16'h23;
    frame(4, 6);
    sel = 1;
    for (int r = 0; r < 6; r++) begin img[r] = 16'h0; expv[r] = 16'h0; end
    img[0] = 16'h1;
    for (int r = 0; r < 3; r++) expv[r] = 16'h7;
    frame(4, 6);
    sel = 0;
    img[0] = 16'h1F; img[1] = 16'h3F;
    expv[0] = 16'h1F; expv[1] = 16'h1F;
    frame(2, 6);
    img[0] = 16'h0; img[1] = 16'hFFF; img[2] = 16'hFFF;
    expv[0] = 16'h0; expv[1] = 16'hC00; expv[2] = 16'hC00;
    frame(3, 12);
    vpulse();
    line(6, 16'h0, 16'h0);
    repeat (2) drive(1, 0, 0, 1, 0, 0);
    repeat (3) drive(0, 0, 0, 0, 0, 0);
    idle(2);
    line(6, 16'h3F, 16'h3F);
    idle(3);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
